// File: rtl/adv7511_init_ctrl.sv
// ADV7511 power-up sequencer: bit-banged I2C master that writes a fixed register
// table after reset, after an HPD rise, or on request.
module adv7511_init_ctrl #(
    parameter int unsigned CLK_DIV   = 93,
    parameter int unsigned PWR_WAIT  = 7425000,
    parameter logic [6:0]  I2C_ADDR  = 7'h39,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic clk_pixel,
    input  logic rst_n,
    input  logic start,
    input  logic hpd_i,
    input  logic sda_i,
    output logic scl_oe,
    output logic sda_oe,
    output logic busy,
    output logic done,
    output logic error,
    output logic video_en
);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PWR_W   = (PWR_WAIT > 1) ? $clog2(PWR_WAIT) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        StIdle, StWaitPwr, StStart, StAddr, StReg, StData, StAck, StStop, StNext, StDone, StError
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [1:0]         r_qtr;
    logic [2:0]         r_bit;
    logic [1:0]         r_byte_sel;
    logic [3:0]         r_idx;
    logic [RETRY_W-1:0] r_retry;
    logic [PWR_W-1:0]   r_pwr_cnt;
    logic               r_ack_ok;
    logic               r_nack;
    logic [1:0]         r_hpd_sync;
    logic               r_hpd_prev;
    logic               r_pending;
    logic               r_scl_oe;
    logic               r_sda_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic        w_qtr_end;
    logic        w_bit_end;
    logic        w_hpd_rise;
    logic        w_timed;
    logic [15:0] w_entry;
    logic [7:0]  w_tx_byte;
    logic        w_scl_drv;
    logic        w_sda_drv;

    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    init_entry = 16'h4110;
            4'd1:    init_entry = 16'h9803;
            4'd2:    init_entry = 16'h9AE0;
            4'd3:    init_entry = 16'h9C30;
            4'd4:    init_entry = 16'h9D61;
            4'd5:    init_entry = 16'hA2A4;
            4'd6:    init_entry = 16'hA3A4;
            4'd7:    init_entry = 16'hE0D0;
            4'd8:    init_entry = 16'hF900;
            4'd9:    init_entry = 16'h1501;
            4'd10:   init_entry = 16'h1635;
            4'd11:   init_entry = 16'h1702;
            4'd12:   init_entry = 16'hAF06;
            default: init_entry = 16'hD6C0;
        endcase
    endfunction

    assign w_entry    = init_entry(r_idx);
    assign w_qtr_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_bit_end  = w_qtr_end && (r_qtr == 2'd3);
    assign w_hpd_rise = r_hpd_sync[1] & ~r_hpd_prev;
    assign w_timed    = (r_state == StStart) || (r_state == StAddr) || (r_state == StReg) ||
                        (r_state == StData) || (r_state == StAck) || (r_state == StStop);

    always_comb begin
        case (r_state)
            StAddr:  w_tx_byte = {I2C_ADDR, 1'b0};
            StReg:   w_tx_byte = w_entry[15:8];
            default: w_tx_byte = w_entry[7:0];
        endcase
    end

    // SDA only moves at quarter 0 of a data bit; START/STOP are the deliberate exceptions.
    always_comb begin
        w_scl_drv = 1'b0;
        w_sda_drv = 1'b0;
        case (r_state)
            StStart: begin
                w_sda_drv = (r_qtr != 2'd0);
                w_scl_drv = (r_qtr == 2'd3);
            end
            StAddr, StReg, StData: begin
                w_scl_drv = ~r_qtr[1];
                w_sda_drv = ~w_tx_byte[3'd7 - r_bit];
            end
            StAck:   w_scl_drv = ~r_qtr[1];
            StStop: begin
                w_scl_drv = (r_qtr == 2'd0);
                w_sda_drv = (r_qtr != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_div      <= '0;
            r_qtr      <= '0;
            r_bit      <= '0;
            r_byte_sel <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_pwr_cnt  <= '0;
            r_ack_ok   <= 1'b0;
            r_nack     <= 1'b0;
            r_hpd_sync <= '0;
            r_hpd_prev <= 1'b0;
            r_pending  <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_hpd_sync <= {r_hpd_sync[0], hpd_i};
            r_hpd_prev <= r_hpd_sync[1];
            r_scl_oe   <= w_scl_drv;
            r_sda_oe   <= w_sda_drv;
            if (w_hpd_rise && r_busy) r_pending <= 1'b1;
            // Every exit from a timed state lands on a bit boundary, so the counters wrap to 0.
            if (w_timed) begin
                if (w_qtr_end) begin
                    r_div <= '0;
                    r_qtr <= r_qtr + 2'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            case (r_state)
                StIdle: begin
                    r_state <= StWaitPwr;
                    r_busy  <= 1'b1;
                end
                StWaitPwr: begin
                    if (r_pwr_cnt == PWR_W'(PWR_WAIT - 1)) begin
                        r_pwr_cnt <= '0;
                        r_idx     <= '0;
                        r_retry   <= '0;
                        r_state   <= StStart;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_bit      <= '0;
                        r_byte_sel <= 2'd0;
                        r_state    <= StAddr;
                    end
                end
                StAddr, StReg, StData: begin
                    if (w_bit_end) begin
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= StAck;
                    end
                end
                StAck: begin
                    if (w_qtr_end && (r_qtr == 2'd2)) r_ack_ok <= ~sda_i;
                    if (w_bit_end) begin
                        if (!r_ack_ok || (r_byte_sel == 2'd2)) begin
                            r_nack  <= ~r_ack_ok;
                            r_state <= StStop;
                        end else begin
                            r_byte_sel <= r_byte_sel + 2'd1;
                            r_state    <= (r_byte_sel == 2'd0) ? StReg : StData;
                        end
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        if (!r_nack) begin
                            r_state <= StNext;
                        end else if (r_retry != RETRY_W'(MAX_RETRY)) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= StStart;
                        end else if (r_pending) begin
                            r_pending <= 1'b0;
                            r_state   <= StWaitPwr;
                        end else begin
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                            r_state <= StError;
                        end
                    end
                end
                StNext: begin
                    if (r_idx != 4'd13) begin
                        r_idx   <= r_idx + 4'd1;
                        r_retry <= '0;
                        r_state <= StStart;
                    end else if (r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= StWaitPwr;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone, StError: begin
                    if (w_hpd_rise) begin
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= StWaitPwr;
                    end else if (start) begin
                        r_idx   <= '0;
                        r_retry <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_state <= StStart;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign scl_oe   = r_scl_oe;
    assign sda_oe   = r_sda_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign video_en = r_done;

endmodule

// File: tb/tb_adv7511_init_ctrl.sv
// Bench for adv7511_init_ctrl: an I2C slave model logs every write transaction and
// the log is compared against the register table expanded by the NACK/retry rules.
module tb_adv7511_init_ctrl;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned PWR_WAIT  = 10;
    localparam int unsigned MAX_RETRY = 3;
    localparam logic [15:0] TBL [14] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
        16'hE0D0, 16'hF900, 16'h1501, 16'h1635, 16'h1702, 16'hAF06, 16'hD6C0
    };

    logic clk_pixel = 1'b0;
    logic rst_n, start, hpd_i, sda_i;
    logic scl_oe, sda_oe, busy, done, error, video_en;
    logic s_drive = 1'b0;

    assign sda_i = !(sda_oe || s_drive);
    always #5 clk_pixel = ~clk_pixel;

    adv7511_init_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .PWR_WAIT (PWR_WAIT),
        .I2C_ADDR (7'h39),
        .MAX_RETRY(MAX_RETRY)
    ) u_dut (
        .clk_pixel(clk_pixel),
        .rst_n    (rst_n),
        .start    (start),
        .hpd_i    (hpd_i),
        .sda_i    (sda_i),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .video_en (video_en)
    );

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] log_q[$];
    logic [31:0] exp_q[$];
    bit          in_xfer = 1'b0;
    int          nbytes = 0;
    bit          nack_addr = 1'b0;
    logic [7:0]  nack_reg = 8'h00;
    int          nack_left = 0;

    // Slave: samples the bus between clock edges; records {nbytes, b0, b1, b2} at each STOP.
    initial begin
        bit scl_p, sda_p, scl_c, sda_c;
        int bitcnt;
        logic [7:0] shreg;
        logic [7:0] rb [3];
        scl_p = 1'b1;
        sda_p = 1'b1;
        bitcnt = 0;
        shreg = 8'h00;
        rb = '{8'h00, 8'h00, 8'h00};
        forever begin
            @(negedge clk_pixel);
            scl_c = !scl_oe;
            sda_c = sda_i;
            if (!rst_n) begin
                in_xfer = 1'b0;
                s_drive = 1'b0;
                bitcnt = 0;
            end else if (scl_p && scl_c && sda_p && !sda_c) begin
                in_xfer = 1'b1;
                bitcnt = 0;
                nbytes = 0;
                rb = '{8'h00, 8'h00, 8'h00};
                s_drive = 1'b0;
            end else if (scl_p && scl_c && !sda_p && sda_c) begin
                if (in_xfer) log_q.push_back({8'(nbytes), rb[0], rb[1], rb[2]});
                in_xfer = 1'b0;
                s_drive = 1'b0;
            end else if (in_xfer && !scl_p && scl_c) begin
                if (bitcnt < 8) shreg = {shreg[6:0], sda_c};
                bitcnt++;
            end else if (in_xfer && scl_p && !scl_c) begin
                if (bitcnt == 8) begin
                    if (nbytes < 3) rb[nbytes] = shreg;
                    if (nack_addr && nbytes == 0) begin
                        s_drive = 1'b0;
                    end else if (nbytes == 2 && rb[1] == nack_reg && nack_left > 0) begin
                        s_drive = 1'b0;
                        nack_left--;
                    end else begin
                        s_drive = 1'b1;
                    end
                    nbytes++;
                end else if (bitcnt == 9) begin
                    bitcnt = 0;
                    s_drive = 1'b0;
                end
            end
            scl_p = scl_c;
            sda_p = sda_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    // One successful write per entry, preceded by nack_cnt NACKed tries of nack_entry.
    task automatic build_pass(input int nack_entry, input int nack_cnt);
        for (int e = 0; e < 14; e++) begin
            for (int r = 0; r <= ((e == nack_entry) ? nack_cnt : 0); r++) begin
                exp_q.push_back({8'd3, 8'h72, TBL[e]});
            end
        end
    endtask

    task automatic compare_log(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s_rec%0d", tag, i), log_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_end(input int budget, input bit poke, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_pixel);
            #1;
            start = 1'b0;
            if (done || error) begin
                ok = 1'b1;
                break;
            end
            if (poke && $urandom_range(0, 199) == 0) start = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_finished"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        hpd_i = 1'b0;
        cycles(3);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_video_en", 32'(video_en), 32'd0);
        rst_n = 1'b1;
        cycles(1);
        chk("idle_to_wait_busy", 32'(busy), 32'd1);

        // Full init with an always-ACK slave; stray start pulses while busy are ignored.
        build_pass(-1, 0);
        wait_end(12000, 1'b1, "t1");
        chk("t1_log_at_done", 32'(log_q.size()), 32'd14);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_video_en", 32'(video_en), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        compare_log("t1");

        // Entry 5 NACKed twice, then accepted; start from DONE skips the power wait.
        log_q.delete();
        exp_q.delete();
        nack_reg = 8'hA2;
        nack_left = 2;
        build_pass(5, 2);
        pulse_start();
        n = 0;
        while (!sda_oe && n < 50) begin
            cycles(1);
            n++;
        end
        chk("t2_skip_wait_pwr", 32'(n < int'(PWR_WAIT)), 32'd1);
        wait_end(12000, 1'b0, "t2");
        chk("t2_done", 32'(done), 32'd1);
        compare_log("t2");

        // Address always NACKed: initial try plus MAX_RETRY retries, then ERROR.
        log_q.delete();
        exp_q.delete();
        nack_addr = 1'b1;
        for (int i = 0; i <= int'(MAX_RETRY); i++) exp_q.push_back({8'd1, 8'h72, 16'h0000});
        pulse_start();
        wait_end(12000, 1'b0, "t3");
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_video_en", 32'(video_en), 32'd0);
        chk("t3_lines_released", {30'd0, scl_oe, sda_oe}, 32'd0);
        compare_log("t3");
        nack_addr = 1'b0;

        // Start from ERROR reruns the table; then an HPD rise in DONE re-inits after WAIT_PWR.
        log_q.delete();
        exp_q.delete();
        build_pass(-1, 0);
        pulse_start();
        wait_end(12000, 1'b0, "t4a");
        chk("t4a_done", 32'(done), 32'd1);
        compare_log("t4a");
        log_q.delete();
        hpd_i = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            n++;
            if (!video_en) break;
        end
        chk("t4_video_drop_3cyc", 32'(n <= 3 && !video_en), 32'd1);
        chk("t4_busy_in_wait", 32'(busy), 32'd1);
        n = 0;
        while (!sda_oe && n < 100) begin
            cycles(1);
            n++;
        end
        // Busy to first SDA pull: the power wait plus START quarter 0 and one output register.
        chk("t4_wait_pwr_len",
            32'(n >= int'(PWR_WAIT + CLK_DIV) && n <= int'(PWR_WAIT + CLK_DIV + 1)), 32'd1);
        wait_end(12000, 1'b0, "t4b");
        chk("t4b_done", 32'(done), 32'd1);
        compare_log("t4b");

        // HPD edge during entry 7 together with start: one pass completes, then a second.
        hpd_i = 1'b0;
        cycles(4);
        log_q.delete();
        exp_q.delete();
        build_pass(-1, 0);
        build_pass(-1, 0);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            cycles(1);
            if (log_q.size() == 7 && in_xfer) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_reach_entry7", 32'(ok), 32'd1);
        hpd_i = 1'b1;
        cycles(2);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_end(20000, 1'b0, "t5");
        chk("t5_done", 32'(done), 32'd1);
        compare_log("t5");

        // Reset while the REG byte of entry 3 is on the wire.
        hpd_i = 1'b0;
        cycles(4);
        log_q.delete();
        exp_q.delete();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            cycles(1);
            if (log_q.size() == 3 && in_xfer && nbytes == 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_reach_entry3_reg", 32'(ok), 32'd1);
        cycles($urandom_range(10, 60));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        cycles(3);
        chk("t6_no_partial_stop", 32'(log_q.size()), 32'd3);
        log_q.delete();
        build_pass(-1, 0);
        rst_n = 1'b1;
        wait_end(12000, 1'b0, "t6");
        chk("t6_done", 32'(done), 32'd1);
        compare_log("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
